// File: rtl/minimig_ram_sequencer.sv
// Minimig board SRAM sequencer: one-hot bank + word offset -> 4 MB word address,
// fixed setup / programmable strobe / hold cycle. Optional macro: MINIMIG_BANK_CHECK_EN.
module minimig_ram_sequencer #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  bank,
  input  logic [17:0] addr,
  input  logic        req,
  input  logic        rd,
  input  logic [1:0]  be_n,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err,
  output logic [20:0] ram_addr,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic [1:0]  ram_be_n,
  output logic [15:0] ram_dout,
  output logic        ram_doe,
  input  logic [15:0] ram_din
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lat_rd;
  logic [IDX_W-1:0] bank_idx;

  // Lowest set bit wins when the mapper presents more than one bank.
  always_comb begin
    bank_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (bank[i]) bank_idx = IDX_W'(i);
    end
  end

`ifdef MINIMIG_BANK_CHECK_EN
  logic multi_bank;
  assign multi_bank = |(bank & (bank - 8'd1));
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_rd   <= 1'b0;
      rdata    <= '0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      ram_addr <= '0;
      ram_ce_n <= 1'b1;
      ram_oe_n <= 1'b1;
      ram_we_n <= 1'b1;
      ram_be_n <= 2'b11;
      ram_dout <= '0;
      ram_doe  <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            busy   <= 1'b1;
            lat_rd <= rd;
            if (bank != 8'd0) begin
              state    <= SETUP;
              ram_addr <= {bank_idx, addr};
              ram_be_n <= be_n;
              ram_ce_n <= 1'b0;
              ram_oe_n <= ~rd;
              ram_doe  <= ~rd;
              if (!rd) ram_dout <= wdata;
`ifdef MINIMIG_BANK_CHECK_EN
              err <= multi_bank;
`endif
            end else begin
              // Unmapped: complete without touching the RAM pins.
              state <= HOLD;
              ack   <= 1'b1;
              if (rd) rdata <= 16'hFFFF;
            end
          end
        end
        SETUP: begin
          state <= STROBE;
          cnt   <= CNT_W'(WAIT_STATES);
          if (!lat_rd) ram_we_n <= 1'b0;
        end
        STROBE: begin
          if (cnt == '0) begin
            state    <= HOLD;
            ack      <= 1'b1;
            ram_we_n <= 1'b1;
            ram_oe_n <= 1'b1;
            if (lat_rd) rdata <= ram_din;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          // Data and CE held one cycle past the strobe release.
          state    <= IDLE;
          busy     <= 1'b0;
          ram_ce_n <= 1'b1;
          ram_doe  <= 1'b0;
          ram_be_n <= 2'b11;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
